// File: rtl/mac_accumulator.sv
// mac_accumulator: Dadda 8x8 multiply feeding an LEN-deep dot-product accumulator.
// Optional: define MAC_SAT_EN to saturate the accumulator on overflow instead of wrapping.

module dadda_mul8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] pp [8];
  logic [15:0] s1 [6];
  logic [15:0] s2 [4];
  logic [15:0] s3 [3];
  logic [15:0] s4 [2];

  function automatic logic [31:0] csa(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z
  );
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {s, c};
  endfunction

  // Row heights follow the Dadda sequence 8 -> 6 -> 4 -> 3 -> 2.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = 16'(b & {8{a[i]}}) << i;
    end
    {s1[0], s1[1]} = csa(pp[0], pp[1], pp[2]);
    {s1[2], s1[3]} = csa(pp[3], pp[4], pp[5]);
    s1[4] = pp[6];
    s1[5] = pp[7];
    {s2[0], s2[1]} = csa(s1[0], s1[1], s1[2]);
    {s2[2], s2[3]} = csa(s1[3], s1[4], s1[5]);
    {s3[0], s3[1]} = csa(s2[0], s2[1], s2[2]);
    s3[2] = s2[3];
    {s4[0], s4[1]} = csa(s3[0], s3[1], s3[2]);
    p = s4[0] + s4[1];
  end

endmodule

module mac_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {
    ACCEPT,
    FLUSH,
    DONE
  } state_t;

  state_t          state;
  logic [7:0]      op_a;
  logic [7:0]      op_b;
  logic            v0;
  logic [15:0]     prod;
  logic            v1;
  logic [15:0]     mul_p;
  logic [CW-1:0]   cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]  sum;
  logic [ACC_W-1:0] acc_nxt;
  logic            hs_in;
  logic            hs_out;

  dadda_mul8 u_mul (
    .a (op_a),
    .b (op_b),
    .p (mul_p)
  );

  assign hs_in   = in_valid & in_ready;
  assign hs_out  = out_valid & out_ready;
  assign out_acc = acc;

  always_comb begin
    sum = {1'b0, acc} + (ACC_W + 1)'(prod);
`ifdef MAC_SAT_EN
    acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCEPT;
      op_a      <= '0;
      op_b      <= '0;
      v0        <= 1'b0;
      prod      <= '0;
      v1        <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      out_ovf   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= ACCEPT;
      v0        <= 1'b0;
      v1        <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      out_ovf   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      v0 <= hs_in;
      if (hs_in) begin
        op_a <= in_a;
        op_b <= in_b;
      end
      v1 <= v0;
      if (v0) prod <= mul_p;
      if (v1) begin
        acc <= acc_nxt;
        if (sum[ACC_W]) out_ovf <= 1'b1;
      end
      unique case (state)
        ACCEPT: begin
          if (hs_in) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        // Last product is in the product register; it lands on this edge.
        FLUSH: begin
          if (!v0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (hs_out) begin
            state     <= ACCEPT;
            acc       <= '0;
            out_ovf   <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: three instances (24/4, 16/2, 32/1)
// share one randomized operand stream; a dot-product model predicts each.

module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic out_ready;

  logic rdy0, rdy1, rdy2;
  logic vld0, vld1, vld2;
  logic ovf0, ovf1, ovf2;
  logic [23:0] acc0;
  logic [15:0] acc1;
  logic [31:0] acc2;

  logic        rdy  [3];
  logic        vld  [3];
  logic        ovf  [3];
  logic [31:0] accs [3];

  localparam int WK [3] = '{24, 16, 32};
  localparam int LK [3] = '{4, 2, 1};

  typedef struct {
    longint acc;
    bit     ovf;
    int     due;
  } exp_t;

  exp_t   sb [3][$];
  longint tot [3];
  int     cnt [3];
  bit     busy [3];
  int     cyc = 0;
  int     tests = 0;
  int     fails = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(24), .LEN(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b),
    .out_valid(vld0), .out_ready(out_ready),
    .out_acc(acc0), .out_ovf(ovf0)
  );

  mac_accumulator #(.ACC_W(16), .LEN(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b),
    .out_valid(vld1), .out_ready(out_ready),
    .out_acc(acc1), .out_ovf(ovf1)
  );

  mac_accumulator #(.ACC_W(32), .LEN(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b),
    .out_valid(vld2), .out_ready(out_ready),
    .out_acc(acc2), .out_ovf(ovf2)
  );

  assign rdy[0] = rdy0;
  assign rdy[1] = rdy1;
  assign rdy[2] = rdy2;
  assign vld[0] = vld0;
  assign vld[1] = vld1;
  assign vld[2] = vld2;
  assign ovf[0] = ovf0;
  assign ovf[1] = ovf1;
  assign ovf[2] = ovf2;
  assign accs[0] = 32'(acc0);
  assign accs[1] = 32'(acc1);
  assign accs[2] = acc2;

  task automatic chk(input string nm, input int k,
                     input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t got %0d expected %0d",
               nm, k, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input longint t, input int w, input int due);
    exp_t e;
    longint mx;
    mx = (64'sd1 <<< w) - 1;
    e.ovf = (t > mx);
`ifdef MAC_SAT_EN
    e.acc = e.ovf ? mx : t;
`else
    e.acc = t & mx;
`endif
    e.due = due;
    return e;
  endfunction

  // Monitor: samples mid-cycle what the next rising edge will act on.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        sb[k].delete();
        tot[k]  = 0;
        cnt[k]  = 0;
        busy[k] = 1'b0;
      end else begin
        chk("in_ready", k, longint'(rdy[k]), longint'(!busy[k]));
        chk("out_valid", k, longint'(vld[k]),
            longint'(sb[k].size() > 0 && cyc >= sb[k][0].due));
        if (vld[k] && sb[k].size() > 0) begin
          chk("out_acc", k, longint'(accs[k]), sb[k][0].acc);
          chk("out_ovf", k, longint'(ovf[k]), longint'(sb[k][0].ovf));
        end
        if (clr) begin
          sb[k].delete();
          tot[k]  = 0;
          cnt[k]  = 0;
          busy[k] = 1'b0;
        end else begin
          if (vld[k] && out_ready && sb[k].size() > 0) begin
            void'(sb[k].pop_front());
            busy[k] = 1'b0;
          end
          if (in_valid && rdy[k]) begin
            tot[k] += longint'(in_a) * longint'(in_b);
            cnt[k]++;
            if (cnt[k] == LK[k]) begin
              sb[k].push_back(mk(tot[k], WK[k], cyc + 3));
              busy[k] = 1'b1;
              tot[k]  = 0;
              cnt[k]  = 0;
            end
          end
        end
      end
    end
  end

  task automatic step(input bit v, input int a, input int b,
                      input bit ordy, input bit c);
    in_valid  = v;
    in_a      = 8'(a);
    in_b      = 8'(b);
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic reset_vals;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", k, longint'(rdy[k]), 1);
      chk("rst_out_valid", k, longint'(vld[k]), 0);
      chk("rst_out_acc", k, longint'(accs[k]), 0);
      chk("rst_out_ovf", k, longint'(ovf[k]), 0);
    end
  endtask

  int va [4];
  int vb [4];
  bit vpat [7];
  int p;

  initial begin
    rst_n = 1'b1;
    clr = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_vals();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // basic dot product
    for (int i = 0; i < 4; i++) step(1'b1, 2*i+1, 2*i+2, 1'b1, 1'b0);
    idle(6);

    // full-scale operands (overflows the 16-bit instance)
    repeat (4) step(1'b1, 255, 255, 1'b1, 1'b0);
    idle(6);
    repeat (2) step(1'b1, 1, 1, 1'b1, 1'b0);
    idle(6);

    // bubbles, then backpressure with stray in_valid pulses
    va = '{2, 4, 6, 8};
    vb = '{3, 5, 7, 9};
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    p = 0;
    for (int i = 0; i < 7; i++) begin
      if (vpat[i]) begin
        step(1'b1, va[p], vb[p], 1'b0, 1'b0);
        p++;
      end else begin
        step(1'b0, 0, 0, 1'b0, 1'b0);
      end
    end
    for (int i = 0; i < 7; i++) step(i[0], 50, 50, 1'b0, 1'b0);
    idle(6);

    // abort a partial vector with clr
    repeat (2) step(1'b1, 9, 9, 1'b1, 1'b0);
    step(1'b1, 7, 7, 1'b1, 1'b1);
    repeat (4) step(1'b1, 1, 1, 1'b1, 1'b0);
    idle(6);

    // asynchronous reset while the LEN=4 instance is flushing
    repeat (4) step(1'b1, 1, 1, 1'b1, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 reset_vals();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // back-to-back singles for the LEN=1 instance
    step(1'b1, 200, 100, 1'b1, 1'b0);
    step(1'b1, 3, 3, 1'b1, 1'b0);
    step(1'b1, 3, 3, 1'b1, 1'b0);
    step(1'b1, 3, 3, 1'b1, 1'b0);
    idle(6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(9) < 7,
           ($urandom_range(3) == 0) ? 255 : int'($urandom_range(255)),
           ($urandom_range(3) == 0) ? 255 : int'($urandom_range(255)),
           $urandom_range(9) < 7,
           $urandom_range(99) == 0);
    end
    idle(10);
    for (int k = 0; k < 3; k++) chk("drained", k, sb[k].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
